rom_lut16x10: RTL and testbench
===============================

// Module: rom_lut16x10
// PURPOSE
//  - Read-only lookup table: 16 entries x 10 bits, entry[i] = i*i (square table).
//  - Synchronous read. The address is sampled on a clock edge; data and valid are registered.
//  - Used as a small constant-coefficient source for datapath blocks that index it with a 4-bit address.
// PARAMETERS
//  - ADDR_W  4   address width; depth = 2**ADDR_W = 16 (fixed table; other values unsupported)
//  - DATA_W  10  data word width; table values zero-extended to DATA_W
// PORTS
//  - clk         in   1       single clock; all state updates on rising edge
//  - rst_n       in   1       reset, synchronous, active-low
//  - rd_en       in   1       read request; addr sampled when high
//  - addr        in   ADDR_W  read address 0..15
//  - data        out  DATA_W  registered read data
//  - data_valid  out  1       high for exactly the cycle after an accepted read
//  - addr_q      out  ADDR_W  address that produced the current data (echo)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-low (clk, rst_n).
//  - Reset (rst_n=0 at posedge): data=0, data_valid=0, addr_q=0. Reset overrides rd_en.
//  - Table contents (hex, addr 0..15):
//      000 001 004 009 010 019 024 031 040 051 064 079 090 0A9 0C4 0E1
//  - Latency: 1 cycle. rd_en=1 at edge N -> data=table[addr], addr_q=addr,
//    data_valid=1, all visible after edge N.
//  - rd_en=0 at an edge: data_valid->0. data and addr_q hold their last values (no glitching to 0).
//  - Back-to-back reads: one read per cycle, no bubbles; data_valid stays high while rd_en is held high.
//  - Address change without rd_en: no effect on outputs.
//  - All 16 addresses are valid; no out-of-range case and no wrap logic.
//  - Reset mid-stream: the read accepted in the same cycle as reset is discarded; the first read after rst_n=1 behaves normally.
//  - X on addr while rd_en=0: must not propagate to outputs.
//  - No write port; contents are constant and synthesize to logic or ROM.
// STRUCTURE
//  - Shared package rom_pkg:
//      - localparams ROM_ADDR_W=4, ROM_DATA_W=10, ROM_DEPTH=16
//      - function sq_entry(addr) returning the table constant
//  - Sub-module rom_lut16x10_table (pure combinational case on addr -> word); the top level adds the output/valid registers.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles with rd_en=1, addr=5 -> data=000, data_valid=0, addr_q=0.
//  - Sweep: rd_en=1, addr=0..9, one per cycle -> data one cycle later =
//    000,001,004,009,010,019,024,031,040,051; data_valid=1 throughout.
//  - Top entries: addr=A..F -> 064,079,090,0A9,0C4,0E1.
//  - Hold: read addr=7 (031), then rd_en=0 and addr=3 -> data stays 031, addr_q=7, data_valid=0.
//  - Reset mid-stream: rd_en=1 addr=9 in the same cycle as rst_n=0 -> data=000, valid=0;
//    next cycle with rst_n=1, addr=9 -> 051, valid=1.
//  - Self-check: compare every read against sq_entry(addr_q); report the mismatch count (must be 0).

Source files
------------

// File: rtl/rom_pkg.sv
// Shared constants and reference function for the 16x10 square-table ROM.
package rom_pkg;

  localparam int unsigned ROM_ADDR_W = 4;
  localparam int unsigned ROM_DATA_W = 10;
  localparam int unsigned ROM_DEPTH  = 16;

  // Table constant for one address: the square of the address.
  function automatic logic [ROM_DATA_W-1:0] sq_entry(input logic [ROM_ADDR_W-1:0] a);
    return ROM_DATA_W'(a) * ROM_DATA_W'(a);
  endfunction

endpackage

// File: rtl/rom_lut16x10_table.sv
// Combinational 16-entry square table; maps a 4-bit address to its 10-bit word.
module rom_lut16x10_table
  import rom_pkg::*;
(
  input  logic [ROM_ADDR_W-1:0] i_addr,
  output logic [ROM_DATA_W-1:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_addr)
      4'h0: o_word = 10'h000;
      4'h1: o_word = 10'h001;
      4'h2: o_word = 10'h004;
      4'h3: o_word = 10'h009;
      4'h4: o_word = 10'h010;
      4'h5: o_word = 10'h019;
      4'h6: o_word = 10'h024;
      4'h7: o_word = 10'h031;
      4'h8: o_word = 10'h040;
      4'h9: o_word = 10'h051;
      4'hA: o_word = 10'h064;
      4'hB: o_word = 10'h079;
      4'hC: o_word = 10'h090;
      4'hD: o_word = 10'h0A9;
      4'hE: o_word = 10'h0C4;
      4'hF: o_word = 10'h0E1;
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/rom_lut16x10.sv
// Registered-read square ROM: one-cycle latency, valid pulse and address echo.
module rom_lut16x10
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic [ADDR_W-1:0] addr_q
);

  logic [ROM_DATA_W-1:0] w_word;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic [ADDR_W-1:0]     r_addr_q;

  rom_lut16x10_table u_table (
    .i_addr (ROM_ADDR_W'(addr)),
    .o_word (w_word)
  );

  // Data and echo load only on an accepted read, so an idle address bus never reaches the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_addr_q <= '0;
    end else begin
      r_valid <= rd_en;
      if (rd_en) begin
        r_data   <= DATA_W'(w_word);
        r_addr_q <= addr;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_valid;
  assign addr_q     = r_addr_q;

endmodule

// File: tb/tb_rom_lut16x10.sv
// Self-checking bench for rom_lut16x10: directed vector table plus a scoreboarded random phase.
module tb_rom_lut16x10;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] addr;
  logic [9:0] data;
  logic       data_valid;
  logic [3:0] addr_q;

  int unsigned errors = 0;
  int unsigned checks = 0;

  rom_lut16x10 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .addr       (addr),
    .data       (data),
    .data_valid (data_valid),
    .addr_q     (addr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       rd_en;
    logic [3:0] addr;
    logic [9:0] exp_data;
    logic       exp_valid;
    logic [3:0] exp_addr_q;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [9:0] data;
  } sb_t;

  logic [9:0] sq_tbl [16] = '{10'h000, 10'h001, 10'h004, 10'h009, 10'h010, 10'h019,
                              10'h024, 10'h031, 10'h040, 10'h051, 10'h064, 10'h079,
                              10'h090, 10'h0A9, 10'h0C4, 10'h0E1};

  vec_t vecs[$];
  sb_t  sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] last_data;
  logic [3:0] last_addr;

  initial begin
    rst_n = 1'b0;
    rd_en = 1'b0;
    addr  = 4'h0;

    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 4'h5, 10'h000, 1'b0, 4'h0});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 1'b1, 4'(i), sq_tbl[i], 1'b1, 4'(i)});
    for (int i = 10; i < 16; i++) vecs.push_back('{1'b1, 1'b1, 4'(i), sq_tbl[i], 1'b1, 4'(i)});
    vecs.push_back('{1'b1, 1'b1, 4'h7, 10'h031, 1'b1, 4'h7});
    vecs.push_back('{1'b1, 1'b0, 4'h3, 10'h031, 1'b0, 4'h7});
    vecs.push_back('{1'b1, 1'b0, 4'hC, 10'h031, 1'b0, 4'h7});
    vecs.push_back('{1'b1, 1'b0, 4'bxxxx, 10'h031, 1'b0, 4'h7});
    vecs.push_back('{1'b1, 1'b1, 4'h2, 10'h004, 1'b1, 4'h2});
    vecs.push_back('{1'b0, 1'b1, 4'h9, 10'h000, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 1'b1, 4'h9, 10'h051, 1'b1, 4'h9});
    vecs.push_back('{1'b1, 1'b1, 4'hF, 10'h0E1, 1'b1, 4'hF});
    vecs.push_back('{1'b1, 1'b1, 4'h0, 10'h000, 1'b1, 4'h0});
    vecs.push_back('{1'b1, 1'b0, 4'h0, 10'h000, 1'b0, 4'h0});

    foreach (vecs[k]) begin
      rst_n = vecs[k].rst_n;
      rd_en = vecs[k].rd_en;
      addr  = vecs[k].addr;
      tick();
      chk($sformatf("vec%0d.valid", k), 32'(data_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d.data", k),  32'(data),       32'(vecs[k].exp_data));
      chk($sformatf("vec%0d.addr_q", k), 32'(addr_q),    32'(vecs[k].exp_addr_q));
    end

    // Random traffic: each accepted read is queued and must emerge on the next edge; idle cycles hold.
    last_data = 10'h000;
    last_addr = 4'h0;
    rst_n     = 1'b1;
    for (int n = 0; n < 80; n++) begin
      rd_en = 1'($urandom_range(0, 1));
      addr  = 4'($urandom_range(0, 15));
      if (rd_en) sb_q.push_back('{addr, sq_tbl[addr]});
      tick();
      if (sb_q.size() != 0) begin
        sb_t e;
        e = sb_q.pop_front();
        chk($sformatf("rnd%0d.valid", n),  32'(data_valid), 32'd1);
        chk($sformatf("rnd%0d.data", n),   32'(data),       32'(e.data));
        chk($sformatf("rnd%0d.addr_q", n), 32'(addr_q),     32'(e.addr));
        last_data = e.data;
        last_addr = e.addr;
      end else begin
        chk($sformatf("rnd%0d.idle_valid", n), 32'(data_valid), 32'd0);
        chk($sformatf("rnd%0d.hold_data", n),  32'(data),       32'(last_data));
        chk($sformatf("rnd%0d.hold_addr", n),  32'(addr_q),     32'(last_addr));
      end
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
